btn_debounce_multi: RTL and testbench
=====================================

# btn_debounce_multi

Multi-channel button conditioner that replaces single-button, single-output debouncing in the board-level control path. Each of `N_CH` raw inputs is synchronised, debounced against a shared millisecond tick, and turned into a stable level plus single-cycle press, release and long-press/auto-repeat event pulses. The block sits between the board pins and the test-mode control logic, so downstream logic never sees bounce or metastability.

## Interface
Parameters:
- `N_CH`, 4: number of independent button channels.
- `FREQUENCY`, 5: clk frequency in MHz. One tick lasts `FREQUENCY*1000` cycles (1 ms).
- `DEBOUNCE_MS`, 20: ticks an input must stay at a new value before the change is accepted (range 1..255).
- `LONG_MS`, 1000: ticks of stable hold before the first `long_press` (range `DEBOUNCE_MS+1`..65535).
- `REPEAT_MS`, 200: ticks between auto-repeat `long_press` pulses after the first one. A value of 0 disables repeat.
- `SYNC_STAGES`, 2: input synchroniser depth (≥2).

Ports:
- `clk` in 1: the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `btn` in `N_CH`: raw buttons, active high, asynchronous to clk.
- `level` out `N_CH`: debounced state per channel.
- `press` out `N_CH`: one-cycle pulse when a press is accepted.
- `release` out `N_CH`: one-cycle pulse when a release is accepted.
- `long_press` out `N_CH`: one-cycle pulse at the long-press point and at each repeat.
- `tick` out 1: the 1 ms prescaler strobe, for debug and bench alignment.

## Operation
- Prescaler:
  - Counter runs 0..`FREQUENCY*1000-1` and wraps.
  - `tick`=1 for exactly one cycle, on the cycle the counter equals its maximum.
  - Every channel shares this prescaler.
- Synchroniser: `SYNC_STAGES` flops per channel, reset to 0. `s` is the last stage output.
- Per-channel FSM with states IDLE, DB_PRESS, HELD, DB_RELEASE, and 8-bit debounce counter `dcnt`:
  - IDLE: if `s`=1, go to DB_PRESS with `dcnt`=0.
  - DB_PRESS:
    - `s`=0: go to IDLE with no event.
    - `tick`: `dcnt`+1. When the incremented value equals `DEBOUNCE_MS`, go to HELD, set `level`=1, pulse `press`, and clear `hcnt`.
  - HELD:
    - `s`=0: go to DB_RELEASE with `dcnt`=0.
    - `tick`: the 16-bit hold counter `hcnt` increments. See the long-press rules below.
  - DB_RELEASE:
    - `s`=1: return to HELD. `hcnt` keeps its value; no event.
    - `tick`: `dcnt`+1. At `DEBOUNCE_MS`, go to IDLE, set `level`=0, pulse `release`.
- Long-press rules (HELD only):
  - The first `long_press` fires on the tick where `hcnt` reaches `LONG_MS`.
  - If `REPEAT_MS`≠0: after that, `hcnt` reloads to `LONG_MS-REPEAT_MS` on each pulse, so a pulse repeats every `REPEAT_MS` ticks.
  - If `REPEAT_MS`=0: `hcnt` saturates at `LONG_MS` and fires no further pulses.
- Simultaneous events:
  - If `s` changes on the same cycle as a tick, the `s` rule wins and the counter is cleared.
  - Channels are fully independent. Any combination of pulses may occur in the same cycle.
- `level` changes only on an accepted press or release; it never follows a rejected glitch.
- Unused state encodings return to IDLE with `level`=0 and no pulse.

## Timing
- Reset values: all outputs 0, prescaler 0, every FSM in IDLE, all counters 0.
  - Reset asserted mid-operation clears all state immediately, with no `release` pulse.
  - The first tick after reset deassertion occurs `FREQUENCY*1000` cycles later.
- All outputs are registered.
  - `press`, `release` and `long_press` are high for exactly one clk cycle.
  - Each pulse is coincident with the `level` update (for press/release), on the cycle after the qualifying tick.
- Latency from a clean `btn` edge to its accepted event:
  - From `SYNC_STAGES` + (`DEBOUNCE_MS`-1)×`FREQUENCY*1000` + 1 cycles
  - Up to `SYNC_STAGES` + `DEBOUNCE_MS`×`FREQUENCY*1000` + 1 cycles.
  - The spread is tick phase.
- A bounce shorter than one tick is always rejected.
- A stable input is accepted within `DEBOUNCE_MS`+1 ticks.

## Test plan
All scenarios use `FREQUENCY`=1 (tick every 1000 cycles), `DEBOUNCE_MS`=3, `LONG_MS`=10, `REPEAT_MS`=4, `N_CH`=4.
- Reset: hold `rst` 5 cycles, with `btn`=4'hF, then release. Outputs stay 0 until the debounce completes, then `press`=4'hF is a single pulse and `level`=4'hF.
- Bounce: on ch0, toggle `btn[0]` every 300 cycles for 5 ms, then hold at 1. Exactly one `press[0]` pulse occurs, between 2 and 3 ticks after the final rising edge; no `release[0]`.
- Glitch reject: drive `btn[1]`=1 for 1500 cycles, then 0. No pulse of any kind on ch1, and `level[1]` stays 0.
- Long press with repeat: hold `btn[2]` for 25 ms. Required response:
  - one `press[2]`;
  - `long_press[2]` 10 ticks after the press, then every 4 ticks (at 10, 14, 18, 22);
  - after the input is dropped, one `release[2]` about 3 ticks later.
- Release bounce: while ch3 is HELD, drop `btn[3]` for 1 ms and restore it. No `release[3]`, and `hcnt` continues, so `long_press[3]` still fires on schedule.
- Simultaneity and reset: press ch0 and ch1 on the same cycle, which must give identical `press` pulses on the same cycle. Then assert `rst` mid-hold: `level` goes to 0 asynchronously, with no `release` pulse.

Source files
------------

// File: rtl/btn_debounce_multi.sv
// Multi-channel button conditioner: synchroniser, tick-based debounce, and press/release/long-press pulses.
// The release pulse port is named release_pulse because "release" is a reserved word.
module btn_debounce_multi #(
  parameter int N_CH        = 4,
  parameter int FREQUENCY   = 5,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   btn,
  output logic [N_CH-1:0]   level,
  output logic [N_CH-1:0]   press,
  output logic [N_CH-1:0]   release_pulse,
  output logic [N_CH-1:0]   long_press,
  output logic              tick,
  output logic [2*N_CH-1:0] dbg_state
);

  localparam int TICK_CYCLES = FREQUENCY * 1000;
  localparam int PW          = $clog2(TICK_CYCLES);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  // tick is registered one cycle early so it is high exactly while pcnt sits at its maximum
  logic [PW-1:0] pcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else begin
      pcnt <= (pcnt == PW'(TICK_CYCLES - 1)) ? '0 : pcnt + PW'(1);
      tick <= (pcnt == PW'(TICK_CYCLES - 2));
    end
  end

  logic [N_CH-1:0] sync_q [SYNC_STAGES];
  logic [N_CH-1:0] s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= btn;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    state_t      state_q, state_d;
    logic [7:0]  dcnt_q, dcnt_d, dcnt_inc;
    logic [15:0] hcnt_q, hcnt_d, hcnt_inc;
    logic        level_q, level_d;
    logic        press_q, press_d;
    logic        rel_q, rel_d;
    logic        long_q, long_d;

    assign dcnt_inc = dcnt_q + 8'd1;
    assign hcnt_inc = hcnt_q + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= IDLE;
        dcnt_q  <= '0;
        hcnt_q  <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        dcnt_q  <= dcnt_d;
        hcnt_q  <= hcnt_d;
        level_q <= level_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        long_q  <= long_d;
      end
    end

    // A change of s always takes priority over a coincident tick
    always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      hcnt_d  = hcnt_q;
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      long_d  = 1'b0;
      case (state_q)
        IDLE: begin
          if (s[c]) begin
            state_d = DB_PRESS;
            dcnt_d  = '0;
          end
        end
        DB_PRESS: begin
          if (!s[c]) begin
            state_d = IDLE;
          end else if (tick) begin
            dcnt_d = dcnt_inc;
            if (dcnt_inc == 8'(DEBOUNCE_MS)) begin
              state_d = HELD;
              level_d = 1'b1;
              press_d = 1'b1;
              hcnt_d  = '0;
            end
          end
        end
        HELD: begin
          if (!s[c]) begin
            state_d = DB_RELEASE;
            dcnt_d  = '0;
          end else if (tick) begin
            // Reloading to LONG_MS-REPEAT_MS makes every later pulse REPEAT_MS ticks apart
            if (hcnt_inc == 16'(LONG_MS)) begin
              long_d = 1'b1;
              hcnt_d = (REPEAT_MS != 0) ? 16'(LONG_MS - REPEAT_MS) : 16'(LONG_MS);
            end else if (hcnt_q != 16'(LONG_MS)) begin
              hcnt_d = hcnt_inc;
            end
          end
        end
        DB_RELEASE: begin
          if (s[c]) begin
            state_d = HELD;
          end else if (tick) begin
            dcnt_d = dcnt_inc;
            if (dcnt_inc == 8'(DEBOUNCE_MS)) begin
              state_d = IDLE;
              level_d = 1'b0;
              rel_d   = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          level_d = 1'b0;
          dcnt_d  = '0;
          hcnt_d  = '0;
        end
      endcase
    end

    assign level[c]            = level_q;
    assign press[c]            = press_q;
    assign release_pulse[c]    = rel_q;
    assign long_press[c]       = long_q;
    assign dbg_state[2*c +: 2] = state_q;
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench for btn_debounce_multi: tick-count model of the debounce rules compared every cycle,
// plus hand-computed event times for each directed scenario.
module tb_btn_debounce_multi;
  localparam int N    = 4;
  localparam int FREQ = 1;
  localparam int DEB  = 3;
  localparam int LONG = 10;
  localparam int REP  = 4;
  localparam int SYNC = 2;
  localparam int P    = FREQ * 1000;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   btn = '0;
  logic [N-1:0]   level, press, release_pulse, long_press;
  logic           tick;
  logic [2*N-1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  btn_debounce_multi #(
    .N_CH(N), .FREQUENCY(FREQ), .DEBOUNCE_MS(DEB),
    .LONG_MS(LONG), .REPEAT_MS(REP), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn),
    .level(level), .press(press), .release_pulse(release_pulse),
    .long_press(long_press), .tick(tick), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Model: n counts clock edges since reset release; the synchronised input is btn delayed SYNC edges.
  int           n = 0;
  logic [N-1:0] m_level = '0, m_press = '0, m_rel = '0, m_long = '0;
  logic         m_tick = 1'b0;

  initial begin : model
    logic [N-1:0] hist[$];
    logic [N-1:0] prev_s, s;
    int           stab[N];
    int           hold[N];
    bit           t;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        n = 0;
        hist.delete();
        for (int i = 0; i < SYNC; i++) hist.push_back('0);
        prev_s = '0;
        m_level = '0; m_press = '0; m_rel = '0; m_long = '0; m_tick = 1'b0;
        for (int c = 0; c < N; c++) begin stab[c] = 0; hold[c] = 0; end
      end else begin
        n++;
        t = (n % P == 0);
        s = hist.pop_front();
        hist.push_back(btn);
        m_press = '0; m_rel = '0; m_long = '0;
        for (int c = 0; c < N; c++) begin
          if (s[c] != prev_s[c]) begin
            stab[c] = 0;
          end else if (t) begin
            if (s[c] != m_level[c]) begin
              stab[c]++;
              if (stab[c] == DEB) begin
                m_level[c] = s[c];
                stab[c] = 0;
                if (s[c]) begin m_press[c] = 1'b1; hold[c] = 0; end
                else m_rel[c] = 1'b1;
              end
            end else if (s[c]) begin
              hold[c]++;
              if (hold[c] == LONG || (REP > 0 && hold[c] > LONG && (hold[c] - LONG) % REP == 0))
                m_long[c] = 1'b1;
            end
          end
        end
        prev_s = s;
        m_tick = ((n + 1) % P == 0);
      end
    end
  end

  int           press_cnt[N], rel_cnt[N], long_cnt[N];
  int           first_press[N], first_long[N], last_long[N], last_rel[N];
  int           first_tick;
  logic [N-1:0] level_seen;

  task automatic clear_log();
    for (int c = 0; c < N; c++) begin
      press_cnt[c] = 0; rel_cnt[c] = 0; long_cnt[c] = 0;
      first_press[c] = -1; first_long[c] = -1; last_long[c] = -1; last_rel[c] = -1;
    end
    first_tick = -1;
    level_seen = '0;
  endtask

  initial begin : compare
    forever begin
      @(negedge clk);
      checks++;
      if ({level, press, release_pulse, long_press, tick} !==
          {m_level, m_press, m_rel, m_long, m_tick}) begin
        errors++;
        $display("FAIL outputs cyc=%0d got level=%h press=%h release=%h long=%h tick=%b need level=%h press=%h release=%h long=%h tick=%b",
                 n, level, press, release_pulse, long_press, tick, m_level, m_press, m_rel, m_long, m_tick);
      end
      if (!rst) begin
        if (tick && first_tick < 0) first_tick = n;
        level_seen = level_seen | level;
        for (int c = 0; c < N; c++) begin
          if (press[c]) begin
            press_cnt[c]++;
            if (first_press[c] < 0) first_press[c] = n;
          end
          if (release_pulse[c]) begin rel_cnt[c]++; last_rel[c] = n; end
          if (long_press[c]) begin
            long_cnt[c]++;
            if (first_long[c] < 0) first_long[c] = n;
            last_long[c] = n;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d need %0d", name, act, exp);
    end
  endtask

  task automatic run_to(input int target);
    while (n < target) @(negedge clk);
  endtask

  task automatic do_reset(input logic [N-1:0] val);
    #2;
    rst = 1'b1;
    btn = val;
    clear_log();
    repeat (5) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : stimulus
    // Reset with all buttons held: one press on every channel at the third tick
    clear_log();
    btn = 4'hF;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    run_to(3500);
    chk("first_tick", first_tick, 999);
    for (int c = 0; c < N; c++) begin
      chk($sformatf("rst_press_cnt%0d", c), press_cnt[c], 1);
      chk($sformatf("rst_press_time%0d", c), first_press[c], 3000);
    end
    chk("rst_level", int'(level), 15);

    // Bounce on ch0: 17 toggles every 300 cycles, ending high at cycle 4900
    do_reset('0);
    for (int k = 0; k <= 16; k++) begin
      run_to(100 + 300 * k);
      btn[0] = (k % 2 == 0);
    end
    run_to(7500);
    chk("bounce_press_cnt", press_cnt[0], 1);
    chk("bounce_press_time", first_press[0], 7000);
    chk("bounce_rel_cnt", rel_cnt[0], 0);

    // Glitch on ch1 of 1500 cycles spans only one tick
    do_reset('0);
    run_to(100);
    btn[1] = 1'b1;
    run_to(1600);
    btn[1] = 1'b0;
    run_to(3500);
    chk("glitch_press_cnt", press_cnt[1], 0);
    chk("glitch_rel_cnt", rel_cnt[1], 0);
    chk("glitch_level_seen", int'(level_seen[1]), 0);

    // ch2 held 25 ms with repeat; ch3 held with a 1 ms drop that freezes its hold count for one tick
    do_reset('0);
    run_to(100);
    btn[3:2] = 2'b11;
    run_to(5500);
    btn[3] = 1'b0;
    run_to(6500);
    btn[3] = 1'b1;
    run_to(25100);
    btn[2] = 1'b0;
    run_to(29000);
    chk("long_press_cnt2", press_cnt[2], 1);
    chk("long_press_time2", first_press[2], 3000);
    chk("long_cnt2", long_cnt[2], 4);
    chk("long_first2", first_long[2], 13000);
    chk("long_last2", last_long[2], 25000);
    chk("long_rel_cnt2", rel_cnt[2], 1);
    chk("long_rel_time2", last_rel[2], 28000);
    chk("relb_rel_cnt3", rel_cnt[3], 0);
    chk("relb_long_first3", first_long[3], 14000);
    chk("relb_long_cnt3", long_cnt[3], 4);

    // Simultaneous press on ch0/ch1, then reset mid-hold
    do_reset('0);
    run_to(100);
    btn[1:0] = 2'b11;
    run_to(5000);
    chk("sim_press_time0", first_press[0], 3000);
    chk("sim_press_time1", first_press[1], 3000);
    chk("sim_level", int'(level), 3);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_level", int'(level), 0);
    btn = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run_to(50);
    chk("rst_no_rel0", rel_cnt[0], 0);
    chk("rst_no_rel1", rel_cnt[1], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
